// File: rtl/rst_seq.sv
// rst_seq: synchronised, ordered release of N_CH active-low resets after a hold-off.
// Define RST_SEQ_SWRST_EN to let i_swrst re-run the sequence without a board reset.
module rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int N_CH        = 4,
    parameter int HOLD_CYC    = 16,
    parameter int GAP_CYC     = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_swrst,
    output logic [N_CH-1:0] o_srstn,
    output logic            o_done
);
    typedef enum logic [2:0] {RESET, SYNC, HOLD, RELEASE, RUN} state_t;
    localparam int MAXC = HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_M1  = CW'(GAP_CYC - 1);
    logic [SYNC_STAGES-1:0] sync;
    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [N_CH-1:0]        srstn_n, srstn_sh;
    logic                   done_n, stall;
    // Channels release strictly in order, so o_srstn is a thermometer code
    assign srstn_sh = N_CH'({o_srstn, 1'b1});
`ifdef RST_SEQ_SWRST_EN
    logic sw_q, sw_n;
    // The first low edge after a soft reset leaves the counter at 0
    assign stall = sw_q;
`else
    logic unused_swrst;
    assign unused_swrst = i_swrst;
    assign stall        = 1'b0;
`endif
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync    <= '0;
            state   <= RESET;
            cnt     <= '0;
            o_srstn <= '0;
            o_done  <= 1'b0;
`ifdef RST_SEQ_SWRST_EN
            sw_q    <= 1'b0;
`endif
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], 1'b1};
            state   <= state_n;
            cnt     <= cnt_n;
            o_srstn <= srstn_n;
            o_done  <= done_n;
`ifdef RST_SEQ_SWRST_EN
            sw_q    <= sw_n;
`endif
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        srstn_n = o_srstn;
        done_n  = o_done;
        case (state)
            RESET: state_n = SYNC;
            SYNC: begin
                if (sync[SYNC_STAGES-1]) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end
            end
            HOLD, RELEASE: begin
                if (!stall) begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == (state == HOLD ? HOLD_M1 : GAP_M1)) begin
                        cnt_n   = '0;
                        srstn_n = srstn_sh;
                        done_n  = srstn_sh[N_CH-1];
                        state_n = srstn_sh[N_CH-1] ? RUN : RELEASE;
                    end
                end
            end
            default: ;
        endcase
`ifdef RST_SEQ_SWRST_EN
        sw_n = 1'b0;
        if (i_swrst && (state == HOLD || state == RELEASE || state == RUN)) begin
            state_n = HOLD;
            cnt_n   = '0;
            srstn_n = '0;
            done_n  = 1'b0;
            sw_n    = 1'b1;
        end
`endif
    end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed checks of release timing, async clear, glitch restart and soft reset.
module tb_rst_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn0 = 1'b1, rstn_b = 1'b1, swrst0 = 1'b0, swrst_b = 1'b0;
    logic [3:0] s0;
    logic [0:0] s1;
    logic [7:0] s2;
    logic d0, d1, d2;
    int total = 0, passed = 0;

    rst_seq u0 (.i_clk(clk), .i_rstn(rstn0), .i_swrst(swrst0), .o_srstn(s0), .o_done(d0));
    rst_seq #(.SYNC_STAGES(3), .N_CH(1), .HOLD_CYC(1), .GAP_CYC(1))
        u1 (.i_clk(clk), .i_rstn(rstn_b), .i_swrst(swrst_b), .o_srstn(s1), .o_done(d1));
    rst_seq #(.SYNC_STAGES(2), .N_CH(8), .HOLD_CYC(16), .GAP_CYC(7))
        u2 (.i_clk(clk), .i_rstn(rstn_b), .i_swrst(swrst_b), .o_srstn(s2), .o_done(d2));

    // Channel k is released at edge ss+1+h+k*g
    function automatic logic [15:0] exp_s(int e, int ss, int n, int h, int g);
        logic [15:0] v = '0;
        for (int k = 0; k < n; k++) if (e >= ss + 1 + h + k * g) v[k] = 1'b1;
        return v;
    endfunction
    function automatic logic exp_d(int e, int ss, int n, int h, int g);
        return e >= ss + 1 + h + (n - 1) * g;
    endfunction

    task automatic test_reset;
        logic [15:0] es;
        #1 rstn0 = 1'b0;
        rstn_b = 1'b0;
        repeat (5) begin
            @(negedge clk);
            total++;
            if ({d0, s0} !== 5'b0) $display("FAIL reset_hold got=%b want=00000", {d0, s0});
            else passed++;
        end
        rstn0 = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            @(posedge clk);
            #1;
            es = exp_s(e, 2, 4, 16, 4);
            total++;
            if ({d0, s0} !== {exp_d(e, 2, 4, 16, 4), es[3:0]})
                $display("FAIL power_on edge=%0d got=%b want=%b", e, {d0, s0}, {exp_d(e, 2, 4, 16, 4), es[3:0]});
            else passed++;
        end
    endtask

    task automatic test_async_mid;
        logic [15:0] es;
        @(negedge clk);
        rstn0 = 1'b0;
        @(negedge clk);
        rstn0 = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk);
            #1;
            es = exp_s(e, 2, 4, 16, 4);
            total++;
            if ({d0, s0} !== {exp_d(e, 2, 4, 16, 4), es[3:0]})
                $display("FAIL pre_abort edge=%0d got=%b want=%b", e, {d0, s0}, {exp_d(e, 2, 4, 16, 4), es[3:0]});
            else passed++;
        end
        #2 rstn0 = 1'b0;
        #1;
        total++;
        if ({d0, s0} !== 5'b0) $display("FAIL async_clear got=%b want=00000", {d0, s0});
        else passed++;
        repeat (2) @(negedge clk);
        rstn0 = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            @(posedge clk);
            #1;
            es = exp_s(e, 2, 4, 16, 4);
            total++;
            if ({d0, s0} !== {exp_d(e, 2, 4, 16, 4), es[3:0]})
                $display("FAIL after_abort edge=%0d got=%b want=%b", e, {d0, s0}, {exp_d(e, 2, 4, 16, 4), es[3:0]});
            else passed++;
        end
    endtask

    task automatic test_glitch;
        logic [15:0] es;
        @(posedge clk);
        #2 rstn0 = 1'b0;
        #1;
        total++;
        if ({d0, s0} !== 5'b0) $display("FAIL glitch_clear got=%b want=00000", {d0, s0});
        else passed++;
        #2 rstn0 = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            @(posedge clk);
            #1;
            es = exp_s(e, 2, 4, 16, 4);
            total++;
            if ({d0, s0} !== {exp_d(e, 2, 4, 16, 4), es[3:0]})
                $display("FAIL glitch_restart edge=%0d got=%b want=%b", e, {d0, s0}, {exp_d(e, 2, 4, 16, 4), es[3:0]});
            else passed++;
        end
    endtask

`ifdef RST_SEQ_SWRST_EN
    // S is r=0; i_swrst sampled high at r=0..2 and low at L=r3, so ch k at r=19+4k
    task automatic sw_round(input int last_r);
        logic [3:0] ev;
        @(negedge clk);
        swrst0 = 1'b1;
        for (int r = 0; r <= last_r; r++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) ev[k] = r >= 19 + 4 * k;
            total++;
            if ({d0, s0} !== {r >= 31, ev})
                $display("FAIL swrst r=%0d got=%b want=%b", r, {d0, s0}, {r >= 31, ev});
            else passed++;
            if (r == 2) swrst0 = 1'b0;
        end
    endtask

    task automatic test_swrst;
        sw_round(35);
        sw_round(24);
        sw_round(35);
    endtask
`else
    task automatic test_swrst;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            swrst0 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            total++;
            if ({d0, s0} !== 5'b11111) $display("FAIL swrst_ignored i=%0d got=%b want=11111", i, {d0, s0});
            else passed++;
        end
        swrst0 = 1'b0;
    endtask
`endif

    task automatic test_sweep;
        logic [15:0] e1, e2;
        @(negedge clk);
        rstn_b = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({d1, s1, d2, s2} !== 11'b0) $display("FAIL sweep_reset got=%b want=0", {d1, s1, d2, s2});
            else passed++;
        end
        rstn_b = 1'b1;
        for (int e = 1; e <= 75; e++) begin
            @(posedge clk);
            #1;
            e1 = exp_s(e, 3, 1, 1, 1);
            e2 = exp_s(e, 2, 8, 16, 7);
            total++;
            if ({d1, s1} !== {exp_d(e, 3, 1, 1, 1), e1[0]})
                $display("FAIL sweep_n1 edge=%0d got=%b want=%b", e, {d1, s1}, {exp_d(e, 3, 1, 1, 1), e1[0]});
            else passed++;
            total++;
            if ({d2, s2} !== {exp_d(e, 2, 8, 16, 7), e2[7:0]})
                $display("FAIL sweep_n8 edge=%0d got=%b want=%b", e, {d2, s2}, {exp_d(e, 2, 8, 16, 7), e2[7:0]});
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_async_mid;
        test_glitch;
        test_swrst;
        test_sweep;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
